// File: rtl/pipelined_cla_adder_if.sv
// Purpose: operand/result bundle for pipelined_cla_adder, with valid/ready on both sides.
// Latency: none; wires only.
// Backpressure: in_ready is driven by the adder and out_ready by the consumer.
// Ports: in_valid/in_ready/a/b/cin/sub (request side); out_valid/out_ready/sum/cout/ovf/zero (result side).
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // master: the producer of operands and consumer of results
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    // slave: the adder itself
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Purpose: WIDTH-bit add/subtract using two-level carry lookahead (GROUP-bit blocks plus block lookahead).
// Latency: 3 clk edges from acceptance to out_valid; 1 result per cycle.
// Backpressure: all stages shift together on advance = ~out_valid | out_ready; in_ready = advance.
// Ports: clk, rst (async, active high); bus (slave modport) carries operands, handshake, sum and flags.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic                 clk,
    input logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int NB = WIDTH / GROUP;

    generate
        if ((GROUP != 2 && GROUP != 4 && GROUP != 8) || (WIDTH % GROUP != 0) ||
            (WIDTH < 4) || (WIDTH > 64)) begin : g_bad_params
            $error("pipelined_cla_adder: illegal WIDTH/GROUP combination");
        end
    endgenerate

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;   // already inverted for subtract
        logic             c;   // effective carry-in
    } s1_t;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NB-1:0]    bp;
        logic [NB-1:0]    bg;
        logic             c;
    } s2_t;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } out_t;

    s1_t            s1_q, s1_d;
    s2_t            s2_q, s2_d;
    out_t           out_q, out_d;
    logic           advance;
    logic [NB:0]    blk_c;
    logic [WIDTH:0] carry;   // carry[i] = carry into bit i; carry[WIDTH] = carry out
    logic [WIDTH-1:0] sum_d;

    assign advance       = ~out_q.vld | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_q.vld;
    assign bus.sum       = out_q.sum;
    assign bus.cout      = out_q.cout;
    assign bus.ovf       = out_q.ovf;
    assign bus.zero      = out_q.zero;

    // Stage 1 input: subtract is A + ~B + 1, so cin is forced high and ignored.
    always_comb begin
        s1_d.vld = bus.in_valid & advance;
        s1_d.a   = bus.a;
        s1_d.b   = bus.sub ? ~bus.b : bus.b;
        s1_d.c   = bus.sub | bus.cin;
    end

    // Stage 2 input: per-bit p/g and per-block propagate/generate.
    // BG[k] = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..1]g[0] within the block.
    always_comb begin : blk_lookahead
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NB-1:0]    bg;
        logic             term;
        p    = s1_q.a ^ s1_q.b;
        g    = s1_q.a & s1_q.b;
        bg   = '0;
        term = 1'b0;
        s2_d.bp = '0;
        for (int k = 0; k < NB; k++) begin
            s2_d.bp[k] = &p[k*GROUP +: GROUP];
            for (int i = 0; i < GROUP; i++) begin
                term = g[k*GROUP + i];
                for (int j = i + 1; j < GROUP; j++) begin
                    term = term & p[k*GROUP + j];
                end
                bg[k] = bg[k] | term;
            end
        end
        s2_d.vld = s1_q.vld;
        s2_d.p   = p;
        s2_d.g   = g;
        s2_d.bg  = bg;
        s2_d.c   = s1_q.c;
    end

    // Block carries as a flat sum of products so no carry ripples between blocks:
    // c[k] = BG[k-1] | BP[k-1]BG[k-2] | ... | BP[k-1..0]c[0].
    always_comb begin : blk_carry
        logic acc;
        logic term;
        acc   = 1'b0;
        term  = 1'b0;
        blk_c = '0;
        blk_c[0] = s2_q.c;
        for (int k = 1; k <= NB; k++) begin
            acc = s2_q.c;
            for (int j = 0; j < k; j++) begin
                acc = acc & s2_q.bp[j];
            end
            for (int i = 0; i < k; i++) begin
                term = s2_q.bg[i];
                for (int j = i + 1; j < k; j++) begin
                    term = term & s2_q.bp[j];
                end
                acc = acc | term;
            end
            blk_c[k] = acc;
        end
    end

    // Bit carries inside each block, looking ahead from that block's carry-in.
    always_comb begin : bit_carry
        logic acc;
        logic term;
        acc   = 1'b0;
        term  = 1'b0;
        carry = '0;
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                acc = blk_c[k];
                for (int j = 0; j < i; j++) begin
                    acc = acc & s2_q.p[k*GROUP + j];
                end
                for (int m = 0; m < i; m++) begin
                    term = s2_q.g[k*GROUP + m];
                    for (int j = m + 1; j < i; j++) begin
                        term = term & s2_q.p[k*GROUP + j];
                    end
                    acc = acc | term;
                end
                carry[k*GROUP + i] = acc;
            end
        end
        carry[WIDTH] = blk_c[NB];
    end

    assign sum_d = s2_q.p ^ carry[WIDTH-1:0];

    always_comb begin
        out_d.vld  = s2_q.vld;
        out_d.sum  = sum_d;
        out_d.cout = carry[WIDTH];
        out_d.ovf  = carry[WIDTH-1] ^ carry[WIDTH];
        out_d.zero = ~|sum_d;
    end

    // Bubbles travel with the data; nothing is compressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            out_q <= '0;
        end else if (advance) begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
`timescale 1ns/1ps
module tb_pipelined_cla_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, cin, sub;
    logic [63:0] a_drv, b_drv;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(16)) if16 ();
    pipelined_cla_adder_if #(.WIDTH(8))  if8  ();
    pipelined_cla_adder_if #(.WIDTH(32)) if32 ();
    pipelined_cla_adder_if #(.WIDTH(64)) if64 ();

    // One shared stimulus stream feeds all four configurations.
    assign if16.in_valid = in_valid;  assign if16.out_ready = out_ready;
    assign if16.cin = cin;            assign if16.sub = sub;
    assign if16.a = a_drv[15:0];      assign if16.b = b_drv[15:0];
    assign if8.in_valid = in_valid;   assign if8.out_ready = out_ready;
    assign if8.cin = cin;             assign if8.sub = sub;
    assign if8.a = a_drv[7:0];        assign if8.b = b_drv[7:0];
    assign if32.in_valid = in_valid;  assign if32.out_ready = out_ready;
    assign if32.cin = cin;            assign if32.sub = sub;
    assign if32.a = a_drv[31:0];      assign if32.b = b_drv[31:0];
    assign if64.in_valid = in_valid;  assign if64.out_ready = out_ready;
    assign if64.cin = cin;            assign if64.sub = sub;
    assign if64.a = a_drv;            assign if64.b = b_drv;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    pipelined_cla_adder #(.WIDTH(8),  .GROUP(2)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    pipelined_cla_adder #(.WIDTH(64), .GROUP(4)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference: plain wide addition, flags from operand/result sign bits.
    task automatic ref_add(input int w, input logic [63:0] av, input logic [63:0] bv,
                           input logic ci, input logic s,
                           output logic [63:0] rs, output logic [2:0] rf);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] am, be;
        logic        co, ov, zr;
        mask = (65'd1 << w) - 65'd1;
        am   = av & mask[63:0];
        be   = (s ? ~bv : bv) & mask[63:0];
        full = {1'b0, am} + {1'b0, be} + {64'd0, (s ? 1'b1 : ci)};
        rs   = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (am[w-1] == be[w-1]) && (rs[w-1] != am[w-1]);
        zr   = (rs == 64'd0);
        rf   = {co, ov, zr};
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    // Single op on the 16-bit instance with out_ready held high; checks latency and result.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic s,
                          input logic [15:0] es, input logic [2:0] ef);
        int lat;
        @(negedge clk);
        a_drv = {48'd0, av}; b_drv = {48'd0, bv};
        cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, if16.in_ready, 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!if16.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_sum"}, if16.sum, es);
        check({tag, "_flags"}, {if16.cout, if16.ovf, if16.zero}, ef);
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic        s;
    } op_t;

    initial begin
        logic [15:0] bp_a [6];
        logic [15:0] bp_b [6];
        logic [15:0] bp_s [6];
        int          sent, rcv, stall, cyc, extra, acc;
        logic        first_seen;
        op_t         q [$];
        op_t         op;
        logic [63:0] rs;
        logic [2:0]  rf;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
        a_drv = 64'd0; b_drv = 64'd0;

        // Reset state
        #12;
        check("rst_out_valid", if16.out_valid, 0);
        check("rst_sum", if16.sum, 0);
        check("rst_flags", {if16.cout, if16.ovf, if16.zero}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_in_ready", if16.in_ready, 1);

        // Directed arithmetic, flags ordered {cout, ovf, zero}
        run_op("add",       16'h1234, 16'h0FCE, 1'b0, 1'b0, 16'h2202, 3'b000);
        run_op("carry",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 3'b101);
        run_op("carry_cin", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 3'b100);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 3'b000);
        run_op("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 3'b010);
        run_op("sub_eq",    16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 3'b101);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 3'b110);
        drain();

        // Back-pressure: six back-to-back ops, 3-cycle stall on the first result
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 16'(i + 1);
            bp_b[i] = 16'((i + 1) * 256);
        end
        bp_s[0] = 16'h0101; bp_s[1] = 16'h0202; bp_s[2] = 16'h0303;
        bp_s[3] = 16'h0404; bp_s[4] = 16'h0505; bp_s[5] = 16'h0606;
        sent = 0; rcv = 0; stall = 0; cyc = 0; first_seen = 1'b0;
        cin = 1'b0; sub = 1'b0;
        while (rcv < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (if16.out_valid && !first_seen) begin
                first_seen = 1'b1;
                stall = 3;
            end
            out_ready = (stall == 0);
            if (sent < 6) begin
                in_valid = 1'b1;
                a_drv = {48'd0, bp_a[sent]};
                b_drv = {48'd0, bp_b[sent]};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall > 0) begin
                check("bp_stall_in_ready", if16.in_ready, 0);
                check("bp_hold_valid", if16.out_valid, 1);
                check("bp_hold_sum", if16.sum, 16'h0101);
                stall--;
            end else if (if16.out_valid) begin
                check($sformatf("bp_result%0d", rcv), if16.sum, bp_s[rcv]);
                rcv++;
            end
            if (in_valid && if16.in_ready) sent++;
        end
        check("bp_all_delivered", rcv, 6);
        extra = 0;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1 if (if16.out_valid) extra++;
        end
        check("bp_no_duplicates", extra, 0);

        // Reset with two ops in flight; pipe accepts into bubbles with out_ready=0
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; sub = 1'b0; cin = 1'b0;
        a_drv = 64'h1111; b_drv = 64'h2222;
        #1 check("bubble_accept_ready", if16.in_ready, 1);
        @(negedge clk);
        a_drv = 64'h3333; b_drv = 64'h4444;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!if16.out_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mid_first_result", if16.sum, 16'h3333);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", if16.out_valid, 0);
        check("mid_rst_sum", if16.sum, 0);
        check("mid_rst_flags", {if16.cout, if16.ovf, if16.zero}, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (if16.out_valid) extra++;
        end
        check("mid_rst_no_stale", extra, 0);
        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 3'b000);

        // Random sweep across all four configurations
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc = 0; cyc = 0;
        while ((acc < 10000 || q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc < 10000) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a_drv = {$urandom(), $urandom()};
                b_drv = {$urandom(), $urandom()};
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (if16.out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_result", 1, 0);
                end else begin
                    op = q.pop_front();
                    ref_add(8, op.a, op.b, op.ci, op.s, rs, rf);
                    check("w8_valid", if8.out_valid, 1);
                    check("w8_sum", {56'd0, if8.sum}, rs);
                    check("w8_flags", {if8.cout, if8.ovf, if8.zero}, rf);
                    ref_add(16, op.a, op.b, op.ci, op.s, rs, rf);
                    check("w16_sum", {48'd0, if16.sum}, rs);
                    check("w16_flags", {if16.cout, if16.ovf, if16.zero}, rf);
                    ref_add(32, op.a, op.b, op.ci, op.s, rs, rf);
                    check("w32_valid", if32.out_valid, 1);
                    check("w32_sum", {32'd0, if32.sum}, rs);
                    check("w32_flags", {if32.cout, if32.ovf, if32.zero}, rf);
                    ref_add(64, op.a, op.b, op.ci, op.s, rs, rf);
                    check("w64_valid", if64.out_valid, 1);
                    check("w64_sum", if64.sum, rs);
                    check("w64_flags", {if64.cout, if64.ovf, if64.zero}, rf);
                end
            end
            if (in_valid && if16.in_ready) begin
                op.a = a_drv; op.b = b_drv; op.ci = cin; op.s = sub;
                q.push_back(op);
                acc++;
            end
        end
        check("rnd_accepted", acc, 10000);
        check("rnd_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
